// File: rtl/wallace_mult_pipe_pkg.sv
// Shared constants, types and elaboration helpers for the pipelined Wallace multiplier.
//   MULT_LATENCY   : cycles from input transfer to out_valid with no stall
//   mult_mode_e    : per-operation operand interpretation
//   wallace_*      : row/level bookkeeping for the generate-built 3:2 reduction tree
package mult_pkg;

  localparam int MULT_LATENCY = 3;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

  // Rows left after one level of 3:2 compression: each full group of three
  // becomes two, leftovers pass straight through.
  function automatic int wallace_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Number of rows present at the input of level lvl (lvl = 0 is the raw tree input).
  function automatic int wallace_rows(input int n, input int lvl);
    int r;
    r = n;
    for (int k = 0; k < lvl; k++) r = wallace_next(r);
    return r;
  endfunction

  // Number of compression levels needed to bring n rows down to two.
  function automatic int wallace_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = wallace_next(r);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_row.sv
// One row of N independent 3:2 full-adder compressors.
//   x_i, y_i, z_i : three addends
//   sum_o         : bitwise sum
//   carry_o       : majority bits shifted up by one (weight already applied);
//                   the carry out of bit N-1 is dropped (arithmetic is mod 2^N)
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] z_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);

  assign sum_o          = x_i ^ y_i ^ z_i;
  assign carry_o[0]     = 1'b0;
  assign carry_o[N-1:1] = (x_i[N-2:0] & y_i[N-2:0]) |
                          (x_i[N-2:0] & z_i[N-2:0]) |
                          (y_i[N-2:0] & z_i[N-2:0]);

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace-tree multiplier with valid/ready
// handshakes on both sides and per-operation signed/unsigned mode.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = pipeline may advance)
//   in_a, in_b           : operands
//   in_signed            : 1 = two's complement, 0 = unsigned
//   in_tag / out_tag     : opaque tag travelling with the operation
//   out_valid / out_ready: product handshake
//   out_p                : 2*WIDTH-bit product (exact modulo 2^(2*WIDTH))
// Stages: S1 partial products, S2 carry-save reduction, S3 carry-propagate add.
module wallace_mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int P      = 2 * WIDTH;
  localparam int LEVELS = wallace_levels(WIDTH);

  logic               advance;
  mult_mode_e         mode;
  logic               pp_bit;
  logic [WIDTH*P-1:0] pp_d;

  logic               s1_valid_q;
  logic [WIDTH*P-1:0] s1_pp_q;
  logic [TAG_W-1:0]   s1_tag_q;

  logic [P-1:0]       red_sum;
  logic [P-1:0]       red_carry;
  logic               s2_valid_q;
  logic [P-1:0]       s2_sum_q;
  logic [P-1:0]       s2_carry_q;
  logic [TAG_W-1:0]   s2_tag_q;

  logic [P-1:0]       p_d;
  logic               out_valid_q;
  logic [P-1:0]       out_p_q;
  logic [TAG_W-1:0]   out_tag_q;

  // The whole pipe moves as one; a held output freezes every stage behind it.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign mode     = in_signed ? MODE_SIGNED : MODE_UNSIGNED;

  // S1: row i holds a & b[i] shifted by i. In signed mode the Baugh-Wooley
  // form inverts the terms where exactly one operand bit is the sign bit and
  // adds 2^WIDTH + 2^(2*WIDTH-1); both constant bits sit in free positions of
  // row 0, so no extra row is needed.
  always_comb begin
    pp_d   = '0;
    pp_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_bit = in_a[j] & in_b[i];
        if (mode == MODE_SIGNED && ((i == WIDTH-1) != (j == WIDTH-1))) pp_bit = ~pp_bit;
        pp_d[i*P + i + j] = pp_bit;
      end
    end
    if (mode == MODE_SIGNED) begin
      pp_d[WIDTH] = 1'b1;
      pp_d[P-1]   = 1'b1;
    end
  end

  // S2: each level compresses groups of three rows into two; leftover rows
  // are forwarded. Every level has its own row vector so no signal feeds back
  // into itself.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NR = wallace_rows(WIDTH, l);
    logic [NR*P-1:0] rows;

    if (l == 0) begin : g_leaf
      assign rows = s1_pp_q;
    end else begin : g_red
      localparam int NP = wallace_rows(WIDTH, l-1);
      localparam int NG = NP / 3;
      for (genvar g = 0; g < NG; g++) begin : g_csa
        csa_row #(.N(P)) u_csa (
          .x_i     (g_lvl[l-1].rows[(3*g)*P   +: P]),
          .y_i     (g_lvl[l-1].rows[(3*g+1)*P +: P]),
          .z_i     (g_lvl[l-1].rows[(3*g+2)*P +: P]),
          .sum_o   (rows[(2*g)*P   +: P]),
          .carry_o (rows[(2*g+1)*P +: P])
        );
      end
      for (genvar r = 0; r < NP % 3; r++) begin : g_pass
        assign rows[(2*NG+r)*P +: P] = g_lvl[l-1].rows[(3*NG+r)*P +: P];
      end
    end
  end

  assign red_sum   = g_lvl[LEVELS].rows[P-1:0];
  assign red_carry = g_lvl[LEVELS].rows[2*P-1:P];

  // S3: final carry-propagate add, truncated to 2*WIDTH bits.
  assign p_d = s2_sum_q + s2_carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_tag_q   <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      // Bubbles leave the last product in place rather than loading junk.
      if (s2_valid_q) begin
        out_p_q   <= p_d;
        out_tag_q <= s2_tag_q;
      end
    end
  end

  // Intermediate data carries no reset; its valid bit decides whether it matters.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_pp_q  <= pp_d;
      s1_tag_q <= in_tag;
    end
    if (advance && s1_valid_q) begin
      s2_sum_q   <= red_sum;
      s2_carry_q <= red_carry;
      s2_tag_q   <= s1_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule
